// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared types and GF(2^8) constants for the sequential AES InvMixColumns block.
package inv_mix_columns_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] K_0E     = 8'h0E;
   localparam logic [7:0] K_0B     = 8'h0B;
   localparam logic [7:0] K_0D     = 8'h0D;
   localparam logic [7:0] K_09     = 8'h09;
   localparam logic [7:0] RED_POLY = 8'h1B;

   // Output row 0 coefficients; row r uses this row rotated right by r bytes.
   localparam logic [0:3][7:0] INV_ROW = {K_0E, K_0B, K_0D, K_09};

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RED_POLY : 8'h00);
   endfunction

   // All inverse coefficients fit in 4 bits, so a 4-deep xtime chain suffices.
   function automatic logic [7:0] gf_mul_k(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = b;
      for (int i = 0; i < 4; i++) begin
         if (k[i]) acc ^= p;
         p = xtime(p);
      end
      return acc;
   endfunction

endpackage

// File: rtl/inv_mix_columns_seq_col.sv
// Combinational InvMixColumns of one 32-bit column; byte 0 is the MSB.
module inv_mix_col
   import inv_mix_columns_seq_pkg::*;
(
   input  logic [31:0] col_in,
   output logic [31:0] col_out
);

   logic [0:3][7:0] s;
   logic [0:3][7:0] o;

   assign s       = col_in;
   assign col_out = o;

   always_comb begin
      for (int r = 0; r < 4; r++) begin
         o[r] = 8'h00;
         for (int j = 0; j < 4; j++)
            o[r] ^= gf_mul_k(s[j], INV_ROW[2'(j - r)][3:0]);
      end
   end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: transforms COLS_PER_CYCLE columns per clock in
// place, then holds the result until the consumer takes it.
module inv_mix_columns_seq
   import inv_mix_columns_seq_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] out_state
);

   localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

   state_t                              state, state_nxt;
   logic [1:0]                          cnt;
   logic [0:3][31:0]                    work;
   logic [COLS_PER_CYCLE-1:0][31:0]     col_sel;
   logic [COLS_PER_CYCLE-1:0][31:0]     col_res;
   logic                                last;

   assign last      = (cnt == LAST_CNT);
   assign out_state = work;

   // Only COLS_PER_CYCLE column engines; the counter picks which columns they see.
   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      assign col_sel[g] = work[cnt + 2'(g)];
      inv_mix_col u_col (
         .col_in  (col_sel[g]),
         .col_out (col_res[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = BUSY;
         BUSY:    if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= 2'd0;
         work <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work <= in_state;
                  cnt  <= 2'd0;
               end
            end
            BUSY: begin
               for (int g = 0; g < COLS_PER_CYCLE; g++)
                  work[cnt + 2'(g)] <= col_res[g];
               cnt <= cnt + 2'(COLS_PER_CYCLE);
            end
            default: ;
         endcase
      end
   end

endmodule
